// File: rtl/sr_ff_pkg.sv
// Shared definitions for the sr_ff_bank flag bank.
// Holds the S=R=1 resolution policy codes and the per-channel next-state function
// used by every sr_ff_cell.
package sr_ff_pkg;

  localparam int unsigned MODE_RST_DOM = 0;
  localparam int unsigned MODE_SET_DOM = 1;
  localparam int unsigned MODE_HOLD    = 2;
  localparam int unsigned MODE_TOGGLE  = 3;

  // Next flip-flop state for one channel given the sampled requests.
  function automatic logic next_q(input logic s, input logic r, input logic q,
                                  input int unsigned mode);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      default: begin
        case (mode)
          MODE_RST_DOM: nq = 1'b0;
          MODE_SET_DOM: nq = 1'b1;
          MODE_HOLD:    nq = q;
          MODE_TOGGLE:  nq = ~q;
          default:      nq = 1'b0;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One channel of the set/reset flag bank: the state flip-flop, its sticky conflict flag and a
// saturating counter of 0->1 transitions.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   s, r        set / reset requests (already synchronised if the bank does so)
//   clr_err     synchronous clear of the conflict flag; a coincident conflict wins
//   q           registered state
//   err         sticky S=R=1 flag
//   cnt         saturating set-event counter
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int unsigned MODE  = MODE_RST_DOM,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             clr_err,
  output logic             q,
  output logic             err,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             q_q, q_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d   = next_q(s, r, q_q, MODE);
    err_d = (s & r) | (err_q & ~clr_err);
    cnt_d = cnt_q;
    // Count rising edges of q, sticking at the maximum instead of wrapping.
    if (q_d && !q_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q   = q_q;
  assign err = err_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N_CH independent clocked set/reset flip-flops with complementary outputs, a
// selectable S=R=1 policy, sticky per-channel conflict flags and saturating set counters.
// Optional macro SR_SYNC_EN: when defined, every s/r bit passes through a 2-flop synchroniser
// (input-to-q latency 3 clk); when undefined inputs are sampled directly (latency 1 clk).
// clr_err is never synchronised.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   s, r        per-channel set / reset requests
//   clr_err     synchronous clear of all conflict flags
//   q, qb       registered state and its exact complement
//   err_ch      sticky per-channel conflict flags, err their OR
//   set_cnt     packed counters, channel i at [i*CNT_W +: CNT_W]
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned MODE  = MODE_RST_DOM,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       s,
  input  logic [N_CH-1:0]       r,
  input  logic                  clr_err,
  output logic [N_CH-1:0]       q,
  output logic [N_CH-1:0]       qb,
  output logic [N_CH-1:0]       err_ch,
  output logic                  err,
  output logic [N_CH*CNT_W-1:0] set_cnt
);

  logic [N_CH-1:0] s_eff;
  logic [N_CH-1:0] r_eff;

`ifdef SR_SYNC_EN
  logic [N_CH-1:0] s_meta_q, s_sync_q;
  logic [N_CH-1:0] r_meta_q, r_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q <= '0;
      s_sync_q <= '0;
      r_meta_q <= '0;
      r_sync_q <= '0;
    end else begin
      s_meta_q <= s;
      s_sync_q <= s_meta_q;
      r_meta_q <= r;
      r_sync_q <= r_meta_q;
    end
  end

  assign s_eff = s_sync_q;
  assign r_eff = r_sync_q;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sr_ff_cell #(
      .MODE  (MODE),
      .CNT_W (CNT_W)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .s       (s_eff[i]),
      .r       (r_eff[i]),
      .clr_err (clr_err),
      .q       (q[i]),
      .err     (err_ch[i]),
      .cnt     (set_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Derived from the single q register, so q=qb=0 cannot occur.
  assign qb  = ~q;
  assign err = |err_ch;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: four instances share stimulus, one per S=R=1 policy; the
// toggle instance uses 2-bit counters to reach saturation quickly.
module tb_sr_ff_bank;

`ifdef SR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       clr_err = 1'b0;

  logic [3:0]  q0, qb0, ec0, q1, qb1, ec1, q2, qb2, ec2, q3, qb3, ec3;
  logic        e0, e1, e2, e3;
  logic [31:0] c0, c1, c2;
  logic [7:0]  c3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.N_CH(4), .MODE(0), .CNT_W(8)) u_m0 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
    .q(q0), .qb(qb0), .err_ch(ec0), .err(e0), .set_cnt(c0));
  sr_ff_bank #(.N_CH(4), .MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
    .q(q1), .qb(qb1), .err_ch(ec1), .err(e1), .set_cnt(c1));
  sr_ff_bank #(.N_CH(4), .MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
    .q(q2), .qb(qb2), .err_ch(ec2), .err(e2), .set_cnt(c2));
  sr_ff_bank #(.N_CH(4), .MODE(3), .CNT_W(2)) u_m3 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
    .q(q3), .qb(qb3), .err_ch(ec3), .err(e3), .set_cnt(c3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle request, then wait until it has reached q.
  task automatic pulse(input logic [3:0] sv, input logic [3:0] rv);
    s = sv;
    r = rv;
    tick(1);
    s = '0;
    r = '0;
    if (LAT > 1) tick(LAT - 1);
  endtask

  initial begin
    // Reset held for three cycles, then idle.
    tick(3);
    check_eq("rst_q", {28'd0, q0}, 32'h0);
    check_eq("rst_qb", {28'd0, qb0}, 32'hF);
    check_eq("rst_cnt", c0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("idle_q", {28'd0, q0}, 32'h0);
      check_eq("idle_qb", {28'd0, qb0}, 32'hF);
      check_eq("idle_err", {31'd0, e0}, 32'h0);
      check_eq("idle_cnt", c0, 32'h0);
    end

    // Basic set / reset on channel 0.
    pulse(4'b0001, 4'b0000);
    check_eq("set_q", {28'd0, q0}, 32'h1);
    check_eq("set_qb", {28'd0, qb0}, 32'hE);
    check_eq("set_cnt0", {24'd0, c0[7:0]}, 32'h1);
    check_eq("set_cnt0_m3", {30'd0, c3[1:0]}, 32'h1);
    pulse(4'b0000, 4'b0001);
    check_eq("rst_q0", {28'd0, q0}, 32'h0);
    check_eq("rst_qb0", {28'd0, qb0}, 32'hF);
    check_eq("rst_cnt0_kept", {24'd0, c0[7:0]}, 32'h1);

    // Conflict on channel 1 after presetting it.
    pulse(4'b0010, 4'b0000);
    check_eq("preset_q1", {28'd0, q0}, 32'h2);
    pulse(4'b0010, 4'b0010);
    check_eq("conf_q_m0", {28'd0, q0}, 32'h0);
    check_eq("conf_q_m1", {28'd0, q1}, 32'h2);
    check_eq("conf_q_m2", {28'd0, q2}, 32'h2);
    check_eq("conf_q_m3", {28'd0, q3}, 32'h0);
    check_eq("conf_qb_m3", {28'd0, qb3}, 32'hF);
    check_eq("conf_ec_m0", {28'd0, ec0}, 32'h2);
    check_eq("conf_ec_m1", {28'd0, ec1}, 32'h2);
    check_eq("conf_ec_m2", {28'd0, ec2}, 32'h2);
    check_eq("conf_ec_m3", {28'd0, ec3}, 32'h2);
    check_eq("conf_err", {28'd0, e0, e1, e2, e3}, 32'hF);
    check_eq("conf_cnt1_m1", {24'd0, c1[15:8]}, 32'h1);

    // Flag is sticky, then cleared by clr_err.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("sticky_ec", {28'd0, ec0}, 32'h2);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check_eq("clr_ec_m0", {28'd0, ec0}, 32'h0);
    check_eq("clr_ec_m3", {28'd0, ec3}, 32'h0);
    check_eq("clr_err", {28'd0, e0, e1, e2, e3}, 32'h0);

    // clr_err on the same edge as a conflict: the conflict wins.
    s = 4'b0010;
    r = 4'b0010;
    for (int k = 0; k < LAT; k++) begin
      clr_err = (k == LAT - 1);
      tick(1);
      s = '0;
      r = '0;
    end
    clr_err = 1'b0;
    check_eq("coinc_ec_m0", {28'd0, ec0}, 32'h2);
    check_eq("coinc_ec_m2", {28'd0, ec2}, 32'h2);
    check_eq("coinc_q_m3", {28'd0, q3}, 32'h2);
    check_eq("coinc_cnt1_m3", {30'd0, c3[3:2]}, 32'h2);
    check_eq("coinc_q_m2", {28'd0, q2}, 32'h2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;

    // Toggle mode with 2-bit counter: q[2] flips each edge, counter sticks at 3.
    s = 4'b0100;
    r = 4'b0100;
    tick(LAT);
    for (int e = 1; e <= 12; e++) begin
      check_eq("tog_q2", {31'd0, q3[2]}, 32'(e % 2));
      check_eq("tog_cnt2", {30'd0, c3[5:4]}, ((e + 1) / 2 > 3) ? 32'd3 : 32'((e + 1) / 2));
      if (e < 12) tick(1);
    end
    check_eq("tog_cnt2_m0", {24'd0, c0[23:16]}, 32'h0);
    check_eq("tog_cnt2_m1", {24'd0, c1[23:16]}, 32'h1);
    check_eq("tog_q_m2", {28'd0, q2}, 32'h2);
    s = '0;
    r = '0;
    tick(LAT);

    // Asynchronous reset between edges while every channel is set and err is pending.
    pulse(4'b1111, 4'b0000);
    check_eq("pre_ar_q", {28'd0, q0}, 32'hF);
    check_eq("pre_ar_err", {31'd0, e0}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_q", {28'd0, q0}, 32'h0);
    check_eq("ar_qb", {28'd0, qb0}, 32'hF);
    check_eq("ar_err", {31'd0, e0}, 32'h0);
    check_eq("ar_ec", {28'd0, ec0}, 32'h0);
    check_eq("ar_cnt_m0", c0, 32'h0);
    check_eq("ar_cnt_m3", {24'd0, c3}, 32'h0);
    check_eq("ar_q_m3", {28'd0, q3}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_eq("post_ar_q", {28'd0, q0}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
